ccg_bench_seq: RTL and testbench

- Parametrised, registered successor of the two-class combinational benchmark cones in the CCGRCG dataset family.
- Evaluates two fixed Boolean functions (class A, class B) over an N_IN-bit input vector and replicates them onto N_OUT outputs per a class mask.
- Adds a valid/ready pipeline with stall support.
- Adds a built-in exhaustive sweep mode that compacts every output vector into a 32-bit MISR signature, used for dataset truth-table labelling.

---
 rtl/ccg_bench_seq.sv | 120 ++++++++++++
 tb/tb_ccg_bench_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ccg_bench_seq.sv
// Two-class Boolean cone evaluator: PIPE-stage valid/ready pipeline plus an exhaustive
// sweep mode that compacts every output vector into a 32-bit MISR signature.
module ccg_bench_seq #(
  parameter int N_IN       = 11,
  parameter int N_OUT      = 13,
  parameter logic [N_OUT-1:0] CLASS_MASK = 13'b1_0111_1000_0000,
  parameter int PIPE       = 2,
  parameter int SWEEP_BITS = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_data,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [31:0]       signature
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [SWEEP_BITS:0] CNT_LAST = {1'b0, {SWEEP_BITS{1'b1}}};

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP, DONE} state_t;

  state_t             state;
  logic [SWEEP_BITS:0] cnt;
  logic [PIPE-1:0]    pv;
  logic [N_OUT-1:0]   pd [PIPE];
  logic [PIPE-1:0]    adv;
  logic [N_IN-1:0]    sweep_vec;
  logic [N_OUT-1:0]   sweep_out;

  function automatic logic [N_OUT-1:0] eval_cone(input logic [N_IN-1:0] x);
    logic a, b;
    logic [N_OUT-1:0] r;
    a = ~x[7] | x[8];
    b = ((~x[0] & ~x[1]) | (x[4] & x[9])) ^ (x[2] & x[10] & ~x[8]);
    for (int i = 0; i < N_OUT; i++) r[i] = CLASS_MASK[i] ? b : a;
    return r;
  endfunction

  // Bit i lands on lane i%32: plain zero-extension for narrow outputs, slice XOR for wide.
  function automatic logic [31:0] fold(input logic [N_OUT-1:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N_OUT; i++) r[i % 32] = r[i % 32] ^ d[i];
    return r;
  endfunction

  always_comb begin
    adv = '0;
    adv[PIPE-1] = ~pv[PIPE-1] | out_ready;
    for (int k = PIPE - 2; k >= 0; k--) adv[k] = ~pv[k] | adv[k+1];
  end

  always_comb begin
    sweep_vec = '0;
    sweep_vec[SWEEP_BITS-1:0] = cnt[SWEEP_BITS-1:0];
  end

  assign sweep_out  = eval_cone(sweep_vec);
  assign in_ready   = adv[0] & (state == IDLE);
  assign out_valid  = pv[PIPE-1];
  assign out_data   = (state == SWEEP) ? sweep_out : pd[PIPE-1];
  assign sweep_busy = (state == DRAIN) | (state == SWEEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int k = 0; k < PIPE; k++) pd[k] <= '0;
    end else begin
      if (adv[0]) begin
        pv[0] <= in_valid & in_ready;
        if (in_valid & in_ready) pd[0] <= eval_cone(in_data);
      end
      for (int k = 1; k < PIPE; k++) begin
        if (adv[k]) begin
          pv[k] <= pv[k-1];
          if (pv[k-1]) pd[k] <= pd[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sweep_done <= 1'b0;
      signature  <= 32'hFFFF_FFFF;
    end else begin
      case (state)
        IDLE: if (sweep_start) begin
          state      <= DRAIN;
          sweep_done <= 1'b0;
        end
        DRAIN: if (~|pv) begin
          state     <= SWEEP;
          cnt       <= '0;
          signature <= 32'hFFFF_FFFF;
        end
        SWEEP: begin
          signature <= {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold(sweep_out);
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          state      <= IDLE;
          sweep_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccg_bench_seq.sv
// Directed-vector bench for ccg_bench_seq: cone values, pipeline flow control, sweep signature.
module tb_ccg_bench_seq;

  localparam logic [12:0] MASK = 13'b1_0111_1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [10:0] in_data;
  logic [12:0] out_data;
  logic        sweep_start, sweep_busy, sweep_done;
  logic [31:0] signature;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ccg_bench_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .signature(signature)
  );

  typedef struct {
    logic [10:0] x;
    logic [12:0] exp;
  } vec_t;

  function automatic logic [12:0] model(input logic [10:0] x);
    logic a, b;
    logic [12:0] r;
    a = ~x[7] | x[8];
    b = ((~x[0] & ~x[1]) | (x[4] & x[9])) ^ (x[2] & x[10] & ~x[8]);
    for (int i = 0; i < 13; i++) r[i] = MASK[i] ? b : a;
    return r;
  endfunction

  function automatic logic [31:0] golden_sig();
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int c = 0; c < 2048; c++)
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ {19'h0, model(11'(c))};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_out_data"}, {19'h0, out_data}, 32'h0);
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    chk({tag, "_busy"}, {31'h0, sweep_busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, sweep_done}, 32'h0);
    chk({tag, "_sig"}, signature, 32'hFFFF_FFFF);
  endtask

  // Pulses sweep_start, then follows the sweep until busy drops; drained outputs are captured.
  task automatic do_sweep(input bit mid_pulse, output int busy, output int bad_ready,
                          output int ndrained, output logic [12:0] d0, output logic [12:0] d1);
    busy = 0; bad_ready = 0; ndrained = 0; d0 = '0; d1 = '0;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    out_ready = 1'b1;
    chk("sweep_done_cleared", {31'h0, sweep_done}, 32'h0);
    #1;
    while (sweep_busy && busy < 5000) begin
      busy++;
      if (in_ready) bad_ready++;
      if (out_valid && out_ready) begin
        if (ndrained == 0) d0 = out_data; else d1 = out_data;
        ndrained++;
      end
      sweep_start = (mid_pulse && busy == 50);
      @(negedge clk);
      sweep_start = 1'b0;
      #1;
    end
    chk("sweep_out_valid_after", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("sweep_done_set", {31'h0, sweep_done}, 32'h1);
  endtask

  vec_t        tbl [8];
  logic [12:0] exp_q [$];
  logic [12:0] held_d, d0, d1, ea, eb;
  logic [31:0] gold;
  bit          held_v;
  int          sent, rcv, busy, bad_ready, nd;

  initial begin
    tbl[0] = '{11'h000, 13'h1FFF};
    tbl[1] = '{11'h080, 13'h1780};
    tbl[2] = '{11'h081, 13'h0000};
    tbl[3] = '{11'h504, 13'h1FFF};
    tbl[4] = '{11'h404, 13'h087F};
    tbl[5] = '{11'h291, 13'h1780};
    tbl[6] = '{11'h182, 13'h087F};
    tbl[7] = '{11'h487, 13'h1780};
    gold = golden_sig();

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sweep_start = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].x;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_lat1_valid", i), {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {31'h0, out_valid}, 32'h1);
      chk($sformatf("tbl%0d_data", i), {19'h0, out_data}, {19'h0, tbl[i].exp});
    end
    @(negedge clk);

    sent = 0; rcv = 0; held_v = 0; held_d = '0;
    for (int cyc = 0; cyc < 300 && rcv < 16; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        chk("stall_valid", {31'h0, out_valid}, 32'h1);
        chk("stall_hold", {19'h0, out_data}, {19'h0, held_d});
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 16);
      in_data   = 11'($urandom_range(0, 2047));
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand_unexpected_out", 32'h1, 32'h0);
        else chk("rand_data", {19'h0, out_data}, {19'h0, exp_q.pop_front()});
        rcv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        sent++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_count", rcv, 32'd16);
    @(negedge clk);

    // Two vectors parked in the pipeline when the sweep is requested.
    ea = model(11'h081);
    eb = model(11'h404);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 11'h081;
    @(negedge clk);
    in_data = 11'h404;
    @(negedge clk);
    in_valid = 1'b0;
    do_sweep(1'b0, busy, bad_ready, nd, d0, d1);
    chk("sweep1_drained", nd, 32'd2);
    chk("sweep1_drain_d0", {19'h0, d0}, {19'h0, ea});
    chk("sweep1_drain_d1", {19'h0, d1}, {19'h0, eb});
    chk("sweep1_busy_min", {31'h0, busy >= 2049}, 32'h1);
    chk("sweep1_busy_max", {31'h0, busy <= 2052}, 32'h1);
    chk("sweep1_in_ready_low", bad_ready, 32'd0);
    chk("sweep1_sig", signature, gold);
    chk("sweep1_in_ready_after", {31'h0, in_ready}, 32'h1);

    do_sweep(1'b1, busy, bad_ready, nd, d0, d1);
    chk("sweep2_busy", busy, 32'd2049);
    chk("sweep2_sig", signature, gold);

    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (102) @(negedge clk);
    chk("mid_busy", {31'h0, sweep_busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_sweep(1'b0, busy, bad_ready, nd, d0, d1);
    chk("sweep3_sig", signature, gold);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
